// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: Hall synchroniser/debounce, RUN/BRAKE/FAULT sequencing,
// PWM chopping, dead-time gated outputs, rotor position tracking and latched faults.
module bldc_commutator #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned DT_W     = 8,
  parameter int unsigned STALL_W  = 24,
  parameter int unsigned POS_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               f_r,
  input  logic               brak,
  input  logic               i_limit,
  input  logic               pwm,
  input  logic [2:0]         hall,
  input  logic [DT_W-1:0]    dead_time,
  input  logic [STALL_W-1:0] stall_limit,
  input  logic               fault_clr,
  output logic [2:0]         hi,
  output logic [2:0]         lo,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic               step,
  output logic [POS_W-1:0]   position
);

  localparam int unsigned     DB_W   = 8;
  localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE - 1);

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_INV   = 2'd1;
  localparam logic [1:0] FC_STALL = 2'd2;
  localparam logic [1:0] FC_SKIP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  function automatic logic code_valid(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  function automatic logic [2:0] code_next(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'b100:  n = 3'b110;
      3'b110:  n = 3'b010;
      3'b010:  n = 3'b011;
      3'b011:  n = 3'b001;
      3'b001:  n = 3'b101;
      3'b101:  n = 3'b100;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] code_prev(input logic [2:0] c);
    logic [2:0] p;
    case (c)
      3'b100:  p = 3'b101;
      3'b110:  p = 3'b100;
      3'b010:  p = 3'b110;
      3'b011:  p = 3'b010;
      3'b001:  p = 3'b011;
      3'b101:  p = 3'b001;
      default: p = 3'b000;
    endcase
    return p;
  endfunction

  // Returns {hi[A:C], lo[A:C]} for a Hall code and rotation direction.
  function automatic logic [5:0] comm_target(input logic [2:0] c, input logic fwd);
    logic [5:0] t;
    case (c)
      3'b100:  t = fwd ? 6'b100_001 : 6'b001_100;
      3'b110:  t = fwd ? 6'b010_001 : 6'b001_010;
      3'b010:  t = fwd ? 6'b010_100 : 6'b100_010;
      3'b011:  t = fwd ? 6'b001_100 : 6'b100_001;
      3'b001:  t = fwd ? 6'b001_010 : 6'b010_001;
      3'b101:  t = fwd ? 6'b100_010 : 6'b010_100;
      default: t = 6'b000_000;
    endcase
    return t;
  endfunction

  logic [2:0]         s1_q, s2_q, hf_q, hf_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               hf_stable, hf_ld, hf_settled;
  logic               valid_chg, ev_fwd, ev_bwd, ev_skip, ev_inv;
  state_e             state_q, state_d;
  logic               fault_q, fault_d;
  logic [1:0]         code_q, code_d;
  logic               step_q;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_hit;
  logic [5:0]         tgt_c, tgt_q;
  logic [5:0]         out_q, out_d;
  logic [DT_W-1:0]    dt_cnt_q, dt_cnt_d;

  // Debounce: counts clocks s2 has held its current value (saturating).
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (s1_q != s2_q) begin
      db_cnt_d = DB_W'(1);
    end else if (db_cnt_q != '1) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign hf_stable  = (s1_q == s2_q) && (db_cnt_q >= DB_LIM);
  assign hf_ld      = hf_stable && (s2_q != hf_q);
  // Filtered code confirmed and no change pending; gates the IDLE invalid-Hall check
  // so the post-reset 000 is not mistaken for a sensor fault.
  assign hf_settled = hf_stable && (s2_q == hf_q);
  assign hf_d       = hf_ld ? s2_q : hf_q;

  assign valid_chg = hf_ld && code_valid(hf_q) && code_valid(s2_q);
  assign ev_fwd    = valid_chg && (s2_q == code_next(hf_q));
  assign ev_bwd    = valid_chg && (s2_q == code_prev(hf_q));
  assign ev_skip   = valid_chg && !ev_fwd && !ev_bwd;
  assign ev_inv    = hf_ld && !code_valid(s2_q);

  assign pos_d = ev_fwd ? pos_q + POS_W'(1) :
                 ev_bwd ? pos_q - POS_W'(1) : pos_q;

  assign stall_cnt_d = ((state_q == ST_RUN) && !valid_chg) ? stall_cnt_q + STALL_W'(1)
                                                           : '0;
  assign stall_hit   = (state_q == ST_RUN) && (stall_limit != '0) &&
                       (stall_cnt_q == stall_limit);

  // Sequencing FSM: next state and fault latch.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (code_valid(hf_q)) begin
            state_d = ST_RUN;
          end else if (hf_settled) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_INV;
          end
        end
      end
      ST_RUN, ST_BRAKE: begin
        if (ev_inv) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_INV;
        end else if (ev_skip) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_SKIP;
        end else if (stall_hit) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_STALL;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end else if ((state_q == ST_RUN) && brak) begin
          state_d = ST_BRAKE;
        end else if ((state_q == ST_BRAKE) && !brak) begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gate target follows the state being entered so off-transitions are never late.
  always_comb begin
    tgt_c = '0;
    unique case (state_d)
      ST_RUN:   tgt_c = comm_target(hf_q, f_r);
      ST_BRAKE: tgt_c = 6'b000_111;
      default:  tgt_c = '0;
    endcase
    tgt_c[5:3] = tgt_c[5:3] & {3{pwm}};
    if (i_limit || !enable) begin
      tgt_c = '0;
    end
  end

  // Dead time: turn-offs immediate, turn-ons wait for a stable target.
  always_comb begin
    dt_cnt_d = dt_cnt_q;
    out_d    = out_q;
    if (tgt_c != tgt_q) begin
      dt_cnt_d = DT_W'(1);
      out_d    = (dead_time == '0) ? tgt_c : (out_q & tgt_c);
    end else if (dt_cnt_q >= dead_time) begin
      out_d = tgt_c;
    end else begin
      dt_cnt_d = dt_cnt_q + DT_W'(1);
      out_d    = out_q & tgt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      hf_q        <= '0;
      db_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      step_q      <= 1'b0;
      pos_q       <= '0;
      stall_cnt_q <= '0;
      tgt_q       <= '0;
      out_q       <= '0;
      dt_cnt_q    <= '0;
    end else begin
      s1_q        <= hall;
      s2_q        <= s1_q;
      hf_q        <= hf_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      step_q      <= valid_chg;
      pos_q       <= pos_d;
      stall_cnt_q <= stall_cnt_d;
      tgt_q       <= tgt_c;
      out_q       <= out_d;
      dt_cnt_q    <= dt_cnt_d;
    end
  end

  assign hi         = out_q[5:3];
  assign lo         = out_q[2:0];
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign step       = step_q;
  assign position   = pos_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed self-checking bench for bldc_commutator (DEBOUNCE=4, POS_W=16).
module tb_bldc_commutator;

  localparam int unsigned DT = 3;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        f_r;
  logic        brak;
  logic        i_limit;
  logic        pwm;
  logic [2:0]  hall;
  logic [7:0]  dead_time;
  logic [23:0] stall_limit;
  logic        fault_clr;
  logic [2:0]  hi;
  logic [2:0]  lo;
  logic        fault;
  logic [1:0]  fault_code;
  logic        step;
  logic [15:0] position;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] cur_hi;
  logic [2:0] cur_lo;

  bldc_commutator #(
    .DEBOUNCE(4),
    .DT_W(8),
    .STALL_W(24),
    .POS_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .f_r(f_r),
    .brak(brak),
    .i_limit(i_limit),
    .pwm(pwm),
    .hall(hall),
    .dead_time(dead_time),
    .stall_limit(stall_limit),
    .fault_clr(fault_clr),
    .hi(hi),
    .lo(lo),
    .fault(fault),
    .fault_code(fault_code),
    .step(step),
    .position(position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_gates(input string tag, input logic [2:0] ehi, input logic [2:0] elo);
    check({tag, "_hi"}, 32'(hi), 32'(ehi));
    check({tag, "_lo"}, 32'(lo), 32'(elo));
  endtask

  task automatic check_fault(input string tag, input logic ef, input logic [1:0] ec);
    check({tag, "_fault"}, 32'(fault), 32'(ef));
    check({tag, "_code"}, 32'(fault_code), 32'(ec));
  endtask

  // One Hall step held 20 clocks; checks pulse, position, turn-off then delayed turn-on.
  task automatic hall_step(input logic [2:0] code, input logic [2:0] ehi,
                           input logic [2:0] elo, input int epos);
    logic [2:0]  ohi;
    logic [2:0]  olo;
    logic [15:0] ep;
    ohi  = cur_hi & ehi;
    olo  = cur_lo & elo;
    ep   = 16'(epos);
    hall = code;
    tick(4);
    check("step_pre", 32'(step), 32'd0);
    tick(1);
    check("step_pulse", 32'(step), 32'd1);
    check("position", 32'(position), 32'(ep));
    tick(1);
    check("step_end", 32'(step), 32'd0);
    check_gates("turn_off", ohi, olo);
    tick(DT - 1);
    check_gates("dead_time", ohi, olo);
    tick(1);
    check_gates("turn_on", ehi, elo);
    cur_hi = ehi;
    cur_lo = elo;
    tick(20 - (6 + DT));
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    f_r         = 1'b1;
    brak        = 1'b0;
    i_limit     = 1'b0;
    pwm         = 1'b1;
    hall        = 3'b100;
    dead_time   = 8'd0;
    stall_limit = 24'd0;
    fault_clr   = 1'b0;
    tick(2);
    check_gates("reset", 3'b000, 3'b000);
    check_fault("reset", 1'b0, 2'd0);
    check("reset_step", 32'(step), 32'd0);
    check("reset_pos", 32'(position), 32'd0);

    // Start-up, dead_time=0: hf loads at edge 5, gates at edge 6.
    rst_n = 1'b1;
    tick(5);
    check_gates("startup_pre", 3'b000, 3'b000);
    check("startup_step", 32'(step), 32'd0);
    tick(1);
    check_gates("startup", 3'b100, 3'b001);
    check_fault("startup", 1'b0, 2'd0);
    cur_hi = 3'b100;
    cur_lo = 3'b001;

    // Forward rotation with dead time.
    dead_time = 8'(DT);
    tick(5);
    hall_step(3'b110, 3'b010, 3'b001, 1);
    hall_step(3'b010, 3'b010, 3'b100, 2);
    hall_step(3'b011, 3'b001, 3'b100, 3);
    hall_step(3'b001, 3'b001, 3'b010, 4);
    hall_step(3'b101, 3'b100, 3'b010, 5);
    hall_step(3'b100, 3'b100, 3'b001, 6);

    // Reverse rotation from a fresh reset.
    f_r   = 1'b0;
    rst_n = 1'b0;
    tick(1);
    check_gates("rst_mid", 3'b000, 3'b000);
    check("rst_mid_pos", 32'(position), 32'd0);
    rst_n = 1'b1;
    tick(20);
    check_gates("rev_start", 3'b001, 3'b100);
    cur_hi = 3'b001;
    cur_lo = 3'b100;
    hall_step(3'b101, 3'b010, 3'b100, -1);
    hall_step(3'b001, 3'b010, 3'b001, -2);
    hall_step(3'b011, 3'b100, 3'b001, -3);
    hall_step(3'b010, 3'b100, 3'b010, -4);
    hall_step(3'b110, 3'b001, 3'b010, -5);
    hall_step(3'b100, 3'b001, 3'b100, -6);

    // Glitch one clock shorter than the debounce window is ignored.
    hall = 3'b110;
    tick(3);
    hall = 3'b100;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_step", 32'(step), 32'd0);
    end
    check_gates("glitch", 3'b001, 3'b100);
    check("glitch_pos", 32'(position), 32'h0000_fffa);

    // Invalid Hall 000 in RUN.
    hall = 3'b000;
    tick(4);
    check_fault("inv_pre", 1'b0, 2'd0);
    tick(1);
    check_fault("inv", 1'b1, 2'd1);
    check_gates("inv", 3'b000, 3'b000);
    tick(5);
    check_fault("inv_hold", 1'b1, 2'd1);
    enable    = 1'b0;
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check_fault("inv_clr", 1'b0, 2'd0);
    hall = 3'b100;
    tick(10);
    check("inv_pos", 32'(position), 32'h0000_fffa);

    // Stall: counter reaches 50 at edge 51 of RUN, fault taken on edge 52.
    f_r         = 1'b1;
    stall_limit = 24'd50;
    enable      = 1'b1;
    tick(51);
    check_fault("stall_pre", 1'b0, 2'd0);
    check_gates("stall_pre", 3'b100, 3'b001);
    tick(1);
    check_fault("stall", 1'b1, 2'd2);
    check_gates("stall", 3'b000, 3'b000);
    stall_limit = 24'd0;
    enable      = 1'b0;
    fault_clr   = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check_fault("stall_clr", 1'b0, 2'd0);

    // Brake entry and exit.
    enable = 1'b1;
    tick(5);
    check_gates("brake_pre", 3'b100, 3'b001);
    brak = 1'b1;
    tick(1);
    check_gates("brake_off", 3'b000, 3'b001);
    tick(DT - 1);
    check_gates("brake_dt", 3'b000, 3'b001);
    tick(1);
    check_gates("brake_on", 3'b000, 3'b111);
    brak = 1'b0;
    tick(1);
    check_gates("unbrake_off", 3'b000, 3'b001);
    tick(DT);
    check_gates("unbrake_on", 3'b100, 3'b001);

    // Sequence skip 100 -> 011.
    hall = 3'b011;
    tick(4);
    check_fault("skip_pre", 1'b0, 2'd0);
    tick(1);
    check_fault("skip", 1'b1, 2'd3);
    check("skip_step", 32'(step), 32'd1);
    check("skip_pos", 32'(position), 32'h0000_fffa);
    check_gates("skip", 3'b000, 3'b000);
    enable    = 1'b0;
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    hall = 3'b100;
    tick(10);
    check_fault("skip_clr", 1'b0, 2'd0);

    // Single-cycle current limit.
    enable = 1'b1;
    tick(5);
    check_gates("ilim_pre", 3'b100, 3'b001);
    i_limit = 1'b1;
    tick(1);
    check_gates("ilim", 3'b000, 3'b000);
    check_fault("ilim", 1'b0, 2'd0);
    i_limit = 1'b0;
    tick(1);
    check_gates("ilim_rel", 3'b000, 3'b000);
    tick(DT - 1);
    check_gates("ilim_dt", 3'b000, 3'b000);
    tick(1);
    check_gates("ilim_on", 3'b100, 3'b001);

    // PWM chopping of the high side only.
    pwm = 1'b0;
    tick(1);
    check_gates("pwm_low", 3'b000, 3'b001);
    tick(3);
    check_gates("pwm_low_hold", 3'b000, 3'b001);
    pwm = 1'b1;
    tick(DT);
    check_gates("pwm_dt", 3'b000, 3'b001);
    tick(1);
    check_gates("pwm_high", 3'b100, 3'b001);

    // Enable drop, then reset while running.
    enable = 1'b0;
    tick(1);
    check_gates("en_drop", 3'b000, 3'b000);
    enable = 1'b1;
    tick(6);
    check_gates("en_back", 3'b100, 3'b001);
    rst_n = 1'b0;
    tick(1);
    check_gates("rst_run", 3'b000, 3'b000);
    check_fault("rst_run", 1'b0, 2'd0);
    check("rst_run_pos", 32'(position), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
